// File: rtl/image_scan_sequencer_pkg.sv
// Shared definitions for the image raster scan path: default raster geometry,
// scan FSM states and the decode from state to its registered outputs.
package image_scan_sequencer_pkg;

    localparam int COL_W   = 4;
    localparam int ROW_W   = 4;
    localparam int PIXEL_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_PX,
        WRITE,
        ADVANCE,
        DONE
    } scan_state_t;

    typedef struct packed {
        logic px_ready;
        logic mem_wr_en;
        logic busy;
        logic frame_done;
    } scan_outs_t;

    // Moore output set of a state; registered together with the state itself.
    function automatic scan_outs_t decode_outputs(input scan_state_t s);
        scan_outs_t o;
        o = '0;
        case (s)
            WAIT_PX: begin
                o.px_ready = 1'b1;
                o.busy     = 1'b1;
            end
            WRITE: begin
                o.mem_wr_en = 1'b1;
                o.busy      = 1'b1;
            end
            ADVANCE: begin
                o.busy = 1'b1;
            end
            DONE: begin
                o.busy       = 1'b1;
                o.frame_done = 1'b1;
            end
            default: o = '0;
        endcase
        return o;
    endfunction

endpackage

// File: rtl/image_scan_sequencer_if.sv
// Pixel-source handshake and frame-buffer write port seen by the scan sequencer.
// The sequencer side is the master; the pixel source / frame buffer side is the slave.
interface image_scan_sequencer_if #(
    parameter int ADDR_W  = image_scan_sequencer_pkg::ROW_W + image_scan_sequencer_pkg::COL_W,
    parameter int PIXEL_W = image_scan_sequencer_pkg::PIXEL_W
);

    logic               px_valid;
    logic [PIXEL_W-1:0] px_data;
    logic               px_ready;
    logic               mem_wr_en;
    logic [ADDR_W-1:0]  mem_addr;
    logic [PIXEL_W-1:0] mem_wdata;
    logic               mem_ack;

    modport master (
        input  px_valid,
        input  px_data,
        input  mem_ack,
        output px_ready,
        output mem_wr_en,
        output mem_addr,
        output mem_wdata
    );

    modport slave (
        output px_valid,
        output px_data,
        output mem_ack,
        input  px_ready,
        input  mem_wr_en,
        input  mem_addr,
        input  mem_wdata
    );

endinterface

// File: rtl/image_scan_sequencer_raster_counter.sv
// Column/row position of the raster scan; the row advances on an enable when
// the column wraps, so both counters live on the one system clock.
module image_scan_sequencer_raster_counter
    import image_scan_sequencer_pkg::*;
#(
    parameter int COL_W = image_scan_sequencer_pkg::COL_W,
    parameter int ROW_W = image_scan_sequencer_pkg::ROW_W
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             clear,
    input  logic             inc,
    output logic [COL_W-1:0] col,
    output logic [ROW_W-1:0] row,
    output logic             at_last
);

    assign at_last = (col == {COL_W{1'b1}}) && (row == {ROW_W{1'b1}});

    // The caller never increments at the last pixel, so the row cannot overflow.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            col <= '0;
            row <= '0;
        end else if (clear) begin
            col <= '0;
            row <= '0;
        end else if (inc) begin
            if (col == {COL_W{1'b1}}) begin
                col <= '0;
                row <= row + ROW_W'(1);
            end else begin
                col <= col + COL_W'(1);
            end
        end
    end

endmodule

// File: rtl/image_scan_sequencer.sv
// Raster scan sequencer: accepts one pixel per handshake and writes it to the
// frame buffer at {row,col}, walking the whole image once per start.
module image_scan_sequencer
    import image_scan_sequencer_pkg::*;
#(
    parameter int COL_W   = image_scan_sequencer_pkg::COL_W,
    parameter int ROW_W   = image_scan_sequencer_pkg::ROW_W,
    parameter int PIXEL_W = image_scan_sequencer_pkg::PIXEL_W
) (
    input  logic                   clk,
    input  logic                   nrst,
    input  logic                   start,
    input  logic                   abort,
    image_scan_sequencer_if.master bus,
    output logic [COL_W-1:0]       col,
    output logic [ROW_W-1:0]       row,
    output logic                   busy,
    output logic                   frame_done
);

    scan_state_t        state;
    scan_state_t        next_state;
    scan_outs_t         outs;
    logic               cnt_clear;
    logic               cnt_inc;
    logic               at_last;
    logic               capture;
    logic [PIXEL_W-1:0] wdata;

    image_scan_sequencer_raster_counter #(
        .COL_W (COL_W),
        .ROW_W (ROW_W)
    ) u_counter (
        .clk     (clk),
        .nrst    (nrst),
        .clear   (cnt_clear),
        .inc     (cnt_inc),
        .col     (col),
        .row     (row),
        .at_last (at_last)
    );

    // Abort outranks every other input, including a same-cycle start or mem_ack.
    always_comb begin
        next_state = state;
        cnt_clear  = 1'b0;
        cnt_inc    = 1'b0;
        capture    = 1'b0;
        if (state == IDLE) begin
            if (start && !abort) begin
                next_state = WAIT_PX;
                cnt_clear  = 1'b1;
            end
        end else if (abort) begin
            next_state = IDLE;
            cnt_clear  = 1'b1;
        end else begin
            case (state)
                WAIT_PX: begin
                    if (bus.px_valid) begin
                        next_state = WRITE;
                        capture    = 1'b1;
                    end
                end
                WRITE: begin
                    if (bus.mem_ack) begin
                        next_state = ADVANCE;
                    end
                end
                ADVANCE: begin
                    if (at_last) begin
                        next_state = DONE;
                    end else begin
                        next_state = WAIT_PX;
                        cnt_inc    = 1'b1;
                    end
                end
                DONE:    next_state = IDLE;
                default: next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            outs  <= '0;
            wdata <= '0;
        end else begin
            state <= next_state;
            outs  <= decode_outputs(next_state);
            if (capture) begin
                wdata <= bus.px_data;
            end else if (abort && state != IDLE) begin
                wdata <= '0;
            end
        end
    end

    assign bus.px_ready  = outs.px_ready;
    assign bus.mem_wr_en = outs.mem_wr_en;
    assign bus.mem_addr  = {row, col};
    assign bus.mem_wdata = wdata;
    assign busy          = outs.busy;
    assign frame_done    = outs.frame_done;

endmodule

// File: tb/tb_image_scan_sequencer.sv
// Self-checking bench for image_scan_sequencer: a pixel-index reference model
// checked every cycle, directed frame/backpressure/abort scenarios, then random traffic.
module tb_image_scan_sequencer;

    logic       clk = 1'b0;
    logic       nrst;
    logic       start;
    logic       abort;
    logic [3:0] col;
    logic [3:0] row;
    logic       busy;
    logic       frame_done;

    image_scan_sequencer_if bus ();

    image_scan_sequencer dut (
        .clk        (clk),
        .nrst       (nrst),
        .start      (start),
        .abort      (abort),
        .bus        (bus),
        .col        (col),
        .row        (row),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    int fd_count = 0;
    int fd_last  = 0;
    logic [23:0] wlog[$];

    // Reference: a scan is a linear pixel index 0..255 moving through
    // accept -> write -> advance, with a one-cycle done phase after pixel 255.
    bit          m_active = 1'b0;
    int          m_stage  = 0;
    int          m_pix    = 0;
    logic [15:0] m_wdata  = '0;

    always @(posedge clk) cyc++;

    always @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            m_active = 1'b0;
            m_stage  = 0;
            m_pix    = 0;
            m_wdata  = '0;
        end else if (!m_active) begin
            if (start && !abort) begin
                m_active = 1'b1;
                m_stage  = 0;
                m_pix    = 0;
            end
        end else if (abort) begin
            m_active = 1'b0;
            m_pix    = 0;
            m_wdata  = '0;
        end else begin
            case (m_stage)
                0: if (bus.px_valid) begin
                    m_wdata = bus.px_data;
                    m_stage = 1;
                end
                1: if (bus.mem_ack) m_stage = 2;
                2: if (m_pix == 255) m_stage = 3;
                   else begin
                       m_pix   = m_pix + 1;
                       m_stage = 0;
                   end
                default: m_active = 1'b0;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        check("px_ready",   bus.px_ready,   m_active && m_stage == 0);
        check("mem_wr_en",  bus.mem_wr_en,  m_active && m_stage == 1);
        check("busy",       busy,           m_active);
        check("frame_done", frame_done,     m_active && m_stage == 3);
        check("mem_addr",   bus.mem_addr,   m_pix);
        check("col",        col,            m_pix % 16);
        check("row",        row,            m_pix / 16);
        check("mem_wdata",  bus.mem_wdata,  m_wdata);
        if (frame_done === 1'b1) begin
            fd_count++;
            fd_last = cyc;
        end
        if (bus.mem_wr_en && bus.mem_ack && !abort && nrst)
            wlog.push_back({bus.mem_addr, bus.mem_wdata});
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutputIdle(input string tag);
        check({tag, "_busy"},   busy,          0);
        check({tag, "_ready"},  bus.px_ready,  0);
        check({tag, "_wr_en"},  bus.mem_wr_en, 0);
        check({tag, "_done"},   frame_done,    0);
        check({tag, "_col"},    col,           0);
        check({tag, "_row"},    row,           0);
        check({tag, "_wdata"},  bus.mem_wdata, 0);
    endtask

    task automatic runUntilPixel(input int pix, input string tag);
        int budget;
        budget = 0;
        while (!(m_active && m_stage == 0 && m_pix == pix) && budget < 1000) begin
            bus.px_data = m_pix[15:0];
            cycle();
            budget++;
        end
        check({tag, "_reached"}, budget < 1000, 1);
        bus.px_data = m_pix[15:0];
    endtask

    task automatic applyStimulus();
        int fd0;
        int s0;
        int bad;
        int budget;

        nrst = 1'b0; start = 1'b0; abort = 1'b0;
        bus.px_valid = 1'b0; bus.px_data = '0; bus.mem_ack = 1'b0;
        repeat (3) cycle();
        checkOutputIdle("reset");
        nrst = 1'b1;

        // px_valid while idle must not be captured
        bus.px_valid = 1'b1; bus.px_data = 16'hA5A5;
        repeat (4) cycle();
        checkOutputIdle("idle_pxvalid");

        // reset asserted while a write is pending
        bus.px_data = 16'hBEEF;
        start = 1'b1; cycle(); start = 1'b0;
        cycle();
        check("midwrite_wr_en", bus.mem_wr_en, 1);
        check("midwrite_wdata", bus.mem_wdata, 32'hBEEF);
        nrst = 1'b0; #1;
        checkOutputIdle("midwrite_reset");
        cycle(); nrst = 1'b1; bus.px_valid = 1'b0; cycle();

        // full frame at maximum throughput, px_data = address
        wlog.delete();
        fd0 = fd_count;
        bus.px_valid = 1'b1; bus.mem_ack = 1'b1; bus.px_data = '0;
        start = 1'b1; s0 = cyc; cycle();
        for (int i = 0; i < 2000 && fd_count == fd0; i++) begin
            start = (i == 100);
            bus.px_data = m_pix[15:0];
            cycle();
        end
        start = 1'b0;
        check("frame_done_count", fd_count - fd0, 1);
        check("frame_latency", fd_last - s0, 769);
        check("frame_writes", wlog.size(), 256);
        if (wlog.size() == 256) begin
            check("addr_0x0f", wlog[15][23:16], 32'h0F);
            check("wrap_0x10", wlog[16][23:16], 32'h10);
            check("addr_last", wlog[255][23:16], 32'hFF);
            bad = 0;
            foreach (wlog[k]) if (wlog[k][15:0] != {8'h00, wlog[k][23:16]} || wlog[k][23:16] != 8'(k)) bad++;
            check("frame_data", bad, 0);
        end
        check("done_hold_col", col, 15);
        check("done_hold_row", row, 15);

        // backpressure at 0x23
        wlog.delete();
        start = 1'b1; cycle(); start = 1'b0;
        runUntilPixel(32'h23, "bp");
        bus.mem_ack = 1'b0;
        cycle();
        for (int i = 0; i < 5; i++) begin
            check("bp_wr_en", bus.mem_wr_en, 1);
            check("bp_addr",  bus.mem_addr,  32'h23);
            check("bp_wdata", bus.mem_wdata, 32'h23);
            check("bp_ready", bus.px_ready,  0);
            cycle();
        end
        bus.mem_ack = 1'b1;

        // abort together with mem_ack at 0x47
        runUntilPixel(32'h47, "abort");
        cycle();
        fd0 = fd_count;
        abort = 1'b1; cycle(); abort = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_col", col, 0);
        check("abort_row", row, 0);
        check("abort_last_write", wlog[$][23:16], 32'h46);
        repeat (3) cycle();
        check("abort_no_done", fd_count - fd0, 0);

        // rescan starts again from address 0
        wlog.delete();
        start = 1'b1; cycle(); start = 1'b0;
        budget = 0;
        while (wlog.size() == 0 && budget < 20) begin
            bus.px_data = m_pix[15:0];
            cycle();
            budget++;
        end
        check("rescan_seen", wlog.size() > 0, 1);
        if (wlog.size() > 0) check("rescan_first_addr", wlog[0][23:16], 0);

        // random traffic against the model
        for (int i = 0; i < 5000; i++) begin
            start        = ($urandom % 16) == 0;
            abort        = ($urandom % 300) == 0;
            bus.px_valid = ($urandom % 4) != 0;
            bus.mem_ack  = ($urandom % 3) != 0;
            bus.px_data  = 16'($urandom);
            nrst         = ($urandom % 2000) != 0;
            cycle();
        end
        nrst = 1'b1; start = 1'b0; abort = 1'b0;
        repeat (2) cycle();
    endtask

    initial begin
        applyStimulus();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
